// File: rtl/dram_word_packer.sv
// dram_word_packer
//
// Assembles 32-bit DRAM read beats into full-width memory words and writes
// them to the weight BRAM, signal ROM, input-feature BRAM or the parameter
// register, depending on the fill phase reported by the DRAM access
// controller. The first beat of a word lands in the LSBs; the assembled
// buffer is truncated to the target width.
//
// Ports
//   clk_i                 rising-edge clock
//   general_rst_i         synchronous active-high reset
//   dram_access_state_i   fill phase: 000 reset, 001 parameters, 010 weights,
//                         011 signals, 100 inputs, 101 filled (others = reset)
//   dram_rd_valid_i       beat present on dram_rd_data_i
//   dram_rd_data_i        DRAM read beat
//   weight_wr_*_o         weight BRAM write strobe / address / word
//   signal_wr_*_o         signal ROM write strobe / address / word
//   input_wr_*_o          input-feature BRAM write strobe / address / word
//   parameters_o          latched parameter word
//   parameters_valid_o    parameters_o holds a loaded word
//   overflow_o            sticky: a word completed on a saturated address
module dram_word_packer #(
  parameter int DATA_IN_DRAM_WIDTH       = 32,
  parameter int PARAMETERS_WIDTH         = 50,
  parameter int ROM_SIG_WIDTH            = 100,
  parameter int N_ROWS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int SIG_ADDRS_WIDTH          = 16,
  parameter int INPUT_FEATURE_ADDR_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                general_rst_i,
  input  logic [2:0]                          dram_access_state_i,
  input  logic                                dram_rd_valid_i,
  input  logic [DATA_IN_DRAM_WIDTH-1:0]       dram_rd_data_i,
  output logic                                weight_wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]          weight_wr_address_o,
  output logic [F_WIDTH*N_ROWS_ARRAY-1:0]     weight_wr_data_o,
  output logic                                signal_wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]          signal_wr_address_o,
  output logic [ROM_SIG_WIDTH-1:0]            signal_wr_data_o,
  output logic                                input_wr_en_o,
  output logic [INPUT_FEATURE_ADDR_WIDTH-1:0] input_wr_address_o,
  output logic [I_WIDTH*N_ROWS_ARRAY-1:0]     input_wr_data_o,
  output logic [PARAMETERS_WIDTH-1:0]         parameters_o,
  output logic                                parameters_valid_o,
  output logic                                overflow_o
);

  localparam int DW       = DATA_IN_DRAM_WIDTH;
  localparam int WEIGHT_W = F_WIDTH * N_ROWS_ARRAY;
  localparam int INPUT_W  = I_WIDTH * N_ROWS_ARRAY;

  function automatic int beats_for(input int width);
    return (width + DW - 1) / DW;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int N_PARAM  = beats_for(PARAMETERS_WIDTH);
  localparam int N_WEIGHT = beats_for(WEIGHT_W);
  localparam int N_SIGNAL = beats_for(ROM_SIG_WIDTH);
  localparam int N_INPUT  = beats_for(INPUT_W);
  localparam int NMAX     = max2(max2(N_PARAM, N_WEIGHT), max2(N_SIGNAL, N_INPUT));
  localparam int BUF_W    = NMAX * DW;
  localparam int CNT_W    = $clog2(NMAX) + 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_PARAM  = 3'd1,
    ST_WEIGHT = 3'd2,
    ST_SIGNAL = 3'd3,
    ST_INPUT  = 3'd4,
    ST_FILLED = 3'd5
  } acc_state_t;

  logic [2:0]                          state_q;
  logic [CNT_W-1:0]                    cnt_q;
  logic [BUF_W-1:0]                    buf_q;
  logic [SIG_ADDRS_WIDTH-1:0]          w_addr_q, s_addr_q;
  logic [INPUT_FEATURE_ADDR_WIDTH-1:0] i_addr_q;
  logic                                w_sat_q, s_sat_q, i_sat_q;

  logic                                state_changed, fill_state, accept, complete;
  logic [CNT_W-1:0]                    n_last, cnt_eff;
  logic [BUF_W-1:0]                    buf_next;
  logic                                entry_w, entry_s, entry_i;
  logic [SIG_ADDRS_WIDTH-1:0]          w_addr_eff, s_addr_eff;
  logic [INPUT_FEATURE_ADDR_WIDTH-1:0] i_addr_eff;
  logic                                w_sat_eff, s_sat_eff, i_sat_eff;

  // Beat acceptance and buffer assembly. A phase change restarts assembly
  // so the beat of the changing cycle becomes beat 0 of the new phase.
  always_comb begin
    fill_state = 1'b1;
    n_last     = '0;
    case (dram_access_state_i)
      ST_PARAM:  n_last = CNT_W'(N_PARAM - 1);
      ST_WEIGHT: n_last = CNT_W'(N_WEIGHT - 1);
      ST_SIGNAL: n_last = CNT_W'(N_SIGNAL - 1);
      ST_INPUT:  n_last = CNT_W'(N_INPUT - 1);
      default:   fill_state = 1'b0;
    endcase
    state_changed = (dram_access_state_i != state_q);
    accept        = dram_rd_valid_i && fill_state;
    cnt_eff       = state_changed ? '0 : cnt_q;
    buf_next      = state_changed ? '0 : buf_q;
    for (int k = 0; k < NMAX; k++) begin
      if (cnt_eff == CNT_W'(k)) buf_next[k*DW +: DW] = dram_rd_data_i;
    end
    complete = accept && (cnt_eff == n_last);

    // Address counters restart on entry; the entry cycle must already see
    // the cleared value in case it completes a word.
    entry_w    = state_changed && (dram_access_state_i == ST_WEIGHT);
    entry_s    = state_changed && (dram_access_state_i == ST_SIGNAL);
    entry_i    = state_changed && (dram_access_state_i == ST_INPUT);
    w_addr_eff = entry_w ? '0 : w_addr_q;
    s_addr_eff = entry_s ? '0 : s_addr_q;
    i_addr_eff = entry_i ? '0 : i_addr_q;
    w_sat_eff  = entry_w ? 1'b0 : w_sat_q;
    s_sat_eff  = entry_s ? 1'b0 : s_sat_q;
    i_sat_eff  = entry_i ? 1'b0 : i_sat_q;
  end

  // Output register stage: strobes, addresses, packed words, parameters.
  always_ff @(posedge clk_i) begin
    if (general_rst_i) begin
      state_q             <= '0;
      cnt_q               <= '0;
      buf_q               <= '0;
      w_addr_q            <= '0;
      s_addr_q            <= '0;
      i_addr_q            <= '0;
      w_sat_q             <= 1'b0;
      s_sat_q             <= 1'b0;
      i_sat_q             <= 1'b0;
      weight_wr_en_o      <= 1'b0;
      weight_wr_address_o <= '0;
      weight_wr_data_o    <= '0;
      signal_wr_en_o      <= 1'b0;
      signal_wr_address_o <= '0;
      signal_wr_data_o    <= '0;
      input_wr_en_o       <= 1'b0;
      input_wr_address_o  <= '0;
      input_wr_data_o     <= '0;
      parameters_o        <= '0;
      parameters_valid_o  <= 1'b0;
      overflow_o          <= 1'b0;
    end else begin
      state_q        <= dram_access_state_i;
      weight_wr_en_o <= 1'b0;
      signal_wr_en_o <= 1'b0;
      input_wr_en_o  <= 1'b0;

      if (accept) begin
        cnt_q <= complete ? '0 : cnt_eff + 1'b1;
        buf_q <= complete ? '0 : buf_next;
      end else if (state_changed) begin
        cnt_q <= '0;
        buf_q <= '0;
      end

      if (entry_w) begin w_addr_q <= '0; w_sat_q <= 1'b0; end
      if (entry_s) begin s_addr_q <= '0; s_sat_q <= 1'b0; end
      if (entry_i) begin i_addr_q <= '0; i_sat_q <= 1'b0; end

      // The all-ones address is written once; the sat flag marks it used.
      if (complete) begin
        case (dram_access_state_i)
          ST_PARAM: begin
            parameters_o       <= buf_next[PARAMETERS_WIDTH-1:0];
            parameters_valid_o <= 1'b1;
          end
          ST_WEIGHT: begin
            if (w_sat_eff) overflow_o <= 1'b1;
            else begin
              weight_wr_en_o      <= 1'b1;
              weight_wr_address_o <= w_addr_eff;
              weight_wr_data_o    <= buf_next[WEIGHT_W-1:0];
              if (&w_addr_eff) w_sat_q  <= 1'b1;
              else             w_addr_q <= w_addr_eff + 1'b1;
            end
          end
          ST_SIGNAL: begin
            if (s_sat_eff) overflow_o <= 1'b1;
            else begin
              signal_wr_en_o      <= 1'b1;
              signal_wr_address_o <= s_addr_eff;
              signal_wr_data_o    <= buf_next[ROM_SIG_WIDTH-1:0];
              if (&s_addr_eff) s_sat_q  <= 1'b1;
              else             s_addr_q <= s_addr_eff + 1'b1;
            end
          end
          ST_INPUT: begin
            if (i_sat_eff) overflow_o <= 1'b1;
            else begin
              input_wr_en_o      <= 1'b1;
              input_wr_address_o <= i_addr_eff;
              input_wr_data_o    <= buf_next[INPUT_W-1:0];
              if (&i_addr_eff) i_sat_q  <= 1'b1;
              else             i_addr_q <= i_addr_eff + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_word_packer.sv
module tb_dram_word_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   state;
  logic         valid;
  logic [31:0]  data;
  logic         weight_wr_en;
  logic [1:0]   weight_wr_address;
  logic [127:0] weight_wr_data;
  logic         signal_wr_en;
  logic [1:0]   signal_wr_address;
  logic [99:0]  signal_wr_data;
  logic         input_wr_en;
  logic [15:0]  input_wr_address;
  logic [127:0] input_wr_data;
  logic [49:0]  parameters;
  logic         parameters_valid;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  dram_word_packer #(.SIG_ADDRS_WIDTH(2)) dut (
    .clk_i               (clk),
    .general_rst_i       (rst),
    .dram_access_state_i (state),
    .dram_rd_valid_i     (valid),
    .dram_rd_data_i      (data),
    .weight_wr_en_o      (weight_wr_en),
    .weight_wr_address_o (weight_wr_address),
    .weight_wr_data_o    (weight_wr_data),
    .signal_wr_en_o      (signal_wr_en),
    .signal_wr_address_o (signal_wr_address),
    .signal_wr_data_o    (signal_wr_data),
    .input_wr_en_o       (input_wr_en),
    .input_wr_address_o  (input_wr_address),
    .input_wr_data_o     (input_wr_data),
    .parameters_o        (parameters),
    .parameters_valid_o  (parameters_valid),
    .overflow_o          (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   tgt;
    logic [15:0]  addr;
    logic [127:0] data;
  } sb_t;

  typedef struct packed {
    logic [2:0]   st;
    logic [127:0] beats;
    logic [2:0]   tgt;
    logic [15:0]  addr;
    logic [127:0] data;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] tgt, input logic [15:0] addr, input logic [127:0] d);
    sb_t e;
    e.tgt  = tgt;
    e.addr = addr;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] st, input logic v, input logic [31:0] d);
    state = st;
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    int   n;
    sb_t  e;
    logic [2:0]   at;
    logic [15:0]  aa;
    logic [127:0] ad;
    n = int'(weight_wr_en) + int'(signal_wr_en) + int'(input_wr_en);
    if (n > 0) begin
      check("single_strobe", 128'(n), 128'd1);
      if (weight_wr_en) begin
        at = 3'd2; aa = {14'b0, weight_wr_address}; ad = weight_wr_data;
      end else if (signal_wr_en) begin
        at = 3'd3; aa = {14'b0, signal_wr_address}; ad = {28'b0, signal_wr_data};
      end else begin
        at = 3'd4; aa = input_wr_address; ad = input_wr_data;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got target %0d addr %0d, expected no write", at, aa);
      end else begin
        e = exp_q.pop_front();
        check("strobe_target", 128'(at), 128'(e.tgt));
        check("strobe_addr", 128'(aa), 128'(e.addr));
        check("strobe_data", ad, e.data);
      end
    end
  end

  initial begin
    logic [31:0]  b[4];
    logic [127:0] w4;

    vecs[0] = '{3'd2, 128'h00000004_00000003_00000002_00000001, 3'd2, 16'd0,
                128'h00000004_00000003_00000002_00000001};
    vecs[1] = '{3'd2, 128'h00000008_00000007_00000006_00000005, 3'd2, 16'd1,
                128'h00000008_00000007_00000006_00000005};
    vecs[2] = '{3'd3, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 3'd3, 16'd0,
                128'h0000000F_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    vecs[3] = '{3'd4, 128'h44444444_33333333_22222222_11111111, 3'd4, 16'd0,
                128'h44444444_33333333_22222222_11111111};
    vecs[4] = '{3'd3, 128'hA5A5A5A5_CAFEF00D_12345678_DEADBEEF, 3'd3, 16'd0,
                128'h00000005_CAFEF00D_12345678_DEADBEEF};
    vecs[5] = '{3'd5, 128'h01020304_05060708_090A0B0C_0D0E0F10, 3'd0, 16'd0, 128'd0};

    rst = 1'b1; state = 3'd0; valid = 1'b0; data = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_weight_en", 128'(weight_wr_en), 128'd0);
    check("rst_weight_addr", 128'(weight_wr_address), 128'd0);
    check("rst_weight_data", weight_wr_data, 128'd0);
    check("rst_signal_data", 128'(signal_wr_data), 128'd0);
    check("rst_input_data", input_wr_data, 128'd0);
    check("rst_params", 128'(parameters), 128'd0);
    check("rst_params_valid", 128'(parameters_valid), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);
    rst = 1'b0;

    // Parameter word: two beats, LSB beat first, truncated to 50 bits.
    drive(3'd1, 1'b1, 32'h89ABCDEF);
    drive(3'd1, 1'b1, 32'h00030123);
    check("params_word", 128'(parameters), 128'h3_0123_89AB_CDEF);
    check("params_valid", 128'(parameters_valid), 128'd1);
    drive(3'd2, 1'b0, 32'h0);
    check("params_hold_valid", 128'(parameters_valid), 128'd1);

    // Table-driven words, back-to-back beats.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3 && vecs[i].tgt != 3'd0) push_exp(vecs[i].tgt, vecs[i].addr, vecs[i].data);
        drive(vecs[i].st, 1'b1, vecs[i].beats[k*32 +: 32]);
      end
    end

    // Mid-word phase change: partial weight word discarded.
    drive(3'd2, 1'b1, 32'hBAD00001);
    drive(3'd2, 1'b1, 32'hBAD00002);
    drive(3'd4, 1'b1, 32'hAAAAAAAA);
    drive(3'd4, 1'b1, 32'hBBBBBBBB);
    drive(3'd4, 1'b1, 32'hCCCCCCCC);
    push_exp(3'd4, 16'd0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    drive(3'd4, 1'b1, 32'hDDDDDDDD);

    // Gaps in valid stall assembly without losing beats.
    drive(3'd4, 1'b1, 32'h0000E000);
    drive(3'd4, 1'b0, 32'hFFFFFFFF);
    drive(3'd4, 1'b0, 32'hFFFFFFFF);
    drive(3'd4, 1'b1, 32'h0000E001);
    drive(3'd4, 1'b0, 32'h12121212);
    drive(3'd4, 1'b1, 32'h0000E002);
    push_exp(3'd4, 16'd1, 128'h0000E003_0000E002_0000E001_0000E000);
    drive(3'd4, 1'b1, 32'h0000E003);

    // Beats in filled and reset phases are dropped.
    for (int k = 0; k < 4; k++) drive(3'd5, 1'b1, 32'h55550000 + k);
    for (int k = 0; k < 4; k++) drive(3'd0, 1'b1, 32'h66660000 + k);
    drive(3'd0, 1'b0, 32'h0);
    check("params_still_word", 128'(parameters), 128'h3_0123_89AB_CDEF);

    // Weight address saturation with a 2-bit address.
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 32'h7000_0000 + 32'(w * 16 + k);
      w4 = {b[3], b[2], b[1], b[0]};
      if (w < 4) push_exp(3'd2, 16'(w), w4);
      for (int k = 0; k < 4; k++) drive(3'd2, 1'b1, b[k]);
      if (w == 3) check("overflow_before_sat", 128'(overflow), 128'd0);
    end
    check("overflow_after_sat", 128'(overflow), 128'd1);
    check("sat_weight_addr_hold", 128'(weight_wr_address), 128'd3);
    check("sat_weight_data_hold", weight_wr_data, 128'h70000033_70000032_70000031_70000030);

    // Reset arriving with the completing beat wins.
    drive(3'd4, 1'b1, 32'h90000000);
    drive(3'd4, 1'b1, 32'h90000001);
    drive(3'd4, 1'b1, 32'h90000002);
    rst = 1'b1;
    drive(3'd4, 1'b1, 32'h90000003);
    check("rst2_input_en", 128'(input_wr_en), 128'd0);
    check("rst2_input_addr", 128'(input_wr_address), 128'd0);
    check("rst2_input_data", input_wr_data, 128'd0);
    check("rst2_weight_addr", 128'(weight_wr_address), 128'd0);
    check("rst2_weight_data", weight_wr_data, 128'd0);
    check("rst2_signal_data", 128'(signal_wr_data), 128'd0);
    check("rst2_params", 128'(parameters), 128'd0);
    check("rst2_params_valid", 128'(parameters_valid), 128'd0);
    check("rst2_overflow", 128'(overflow), 128'd0);
    rst = 1'b0;

    // After reset, weight addressing restarts at 0.
    push_exp(3'd2, 16'd0, 128'h00000D04_00000D03_00000D02_00000D01);
    for (int k = 0; k < 4; k++) drive(3'd2, 1'b1, 32'h00000D01 + 32'(k));
    drive(3'd5, 1'b0, 32'h0);
    drive(3'd5, 1'b0, 32'h0);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
